latch_write_arbiter: RTL and testbench
======================================

Name: latch_write_arbiter

Overview:
Shares one D-latch storage word (D/EN/R interface) between NREQ requesters using round-robin arbitration. Sequences each write as setup → enable → hold, so D is stable before EN rises and after EN falls. Returns a one-cycle ACK to the winning requester. Sits between the clocked control logic and the latch bank; LEN drives the latch EN and LD drives the latch D.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of the latch word
SETUP_CYC, 1, cycles LD is stable before LEN rises (>=1)
EN_CYC, 2, cycles LEN is held high (>=1)
HOLD_CYC, 1, cycles LD is held stable after LEN falls (>=1)

Ports:
CLK  in  1  system clock, rising-edge
R  in  1  reset, asynchronous, active-low
REQ  in  NREQ  write request per requester; level, held until ACK
WDATA  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH]
ACK  out  NREQ  one-cycle completion pulse to the granted requester
GNT_ID  out  $clog2(NREQ)  index of the current or last granted requester
BUSY  out  1  high from grant until the cycle after ACK
LD  out  WIDTH  data to latch D; registered
LEN  out  1  latch enable; registered, glitch-free

Behaviour:
- Reset (R=0, asynchronous): state=IDLE; LEN=0, LD=0, ACK=0, BUSY=0, GNT_ID=0; round-robin pointer=0, so requester 0 has highest priority.
- States: IDLE, SETUP, ENABLE, HOLD, DONE. A single down-counter times the SETUP, ENABLE and HOLD phases.
- IDLE with any REQ bit high at a clock edge:
  - Winner = first set REQ bit searching upward from the pointer, wrapping modulo NREQ.
  - GNT_ID=winner; LD=WDATA slice of the winner; BUSY=1.
  - Pointer = winner+1 (mod NREQ); go to SETUP.
- SETUP lasts SETUP_CYC cycles, then ENABLE.
- ENABLE: LEN=1 for exactly EN_CYC cycles, then HOLD with LEN=0.
- HOLD lasts HOLD_CYC cycles, then DONE.
- DONE lasts 1 cycle: ACK[GNT_ID]=1; all other ACK bits stay 0. Then IDLE, where ACK=0 and BUSY=0.
- With default parameters and the grant at edge E0:
  - LEN high after E1 and E2; low after E3.
  - ACK high after E4; IDLE after E5.
  - The earliest next grant is at E6, so one transfer takes 6 cycles.
- LD changes only at a grant edge. It holds its value in every other state, including IDLE after completion, so the latch never sees D change while LEN=1 or during hold.
- WDATA and REQ changes after the grant edge are ignored for the current transfer.
- A requester that drops REQ mid-transfer still receives its ACK; the write completes.
- A requester whose REQ is still high in the cycle after ACK is treated as a new request. Round-robin prevents it from starving the others.
- Simultaneous requests are resolved purely by the pointer. Wrap-around: with pointer=3 and REQ=4'b0011, the winner is 0.
- No requests: stays in IDLE; LEN=0; outputs hold.
- Reset mid-operation: LEN drops to 0 immediately and asynchronously. The transfer is abandoned with no ACK, and all outputs and the pointer return to reset values.
- The latch reset is not driven by this block; R is distributed to the latch separately.

Decomposition:
- Package latch_ctrl_pkg:
  - state_t enum {IDLE, SETUP, ENABLE, HOLD, DONE}
  - counter-width constant computed from max(SETUP_CYC, EN_CYC, HOLD_CYC)
- Sub-module rr_arbiter:
  - Parameter NREQ; inputs REQ and pointer; outputs winner index and valid.
  - Purely combinational.
- The top level holds the FSM, the phase counter, the pointer register and the LD/LEN registers.

Test Plan:
- Reset then idle: hold R=0 for 2 cycles, release, REQ=0 for 10 cycles → LEN=0, LD=0, ACK=0, BUSY=0 throughout.
- Single write: REQ=4'b0100, WDATA slice 2=8'hA5 at E0 → GNT_ID=2 and LD=8'hA5 after E0; LEN=1 only after E1–E2; ACK=4'b0100 only after E4; BUSY=0 after E5.
- Contention and round-robin: REQ=4'b1111 held constant, slice i = 8'h10+i → grants in order 0,1,2,3,0, each 6 cycles apart; LD follows 8'h10, 8'h11, 8'h12, 8'h13.
- Wrap-around: after a grant to 3, REQ=4'b0011 → winner 0, then 1.
- Stability: change WDATA of the granted requester to 8'hFF and drop its REQ during ENABLE → LD unchanged while LEN=1 and during HOLD; ACK still issued.
- Reset mid-operation: assert R=0 while LEN=1 → LEN=0 within the same cycle with no clock edge; no ACK; after release, the next grant goes to requester 0 with REQ=4'b1111.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg
//   Shared types and helpers for the latch write arbiter.
//   state_t   : write sequencer states (IDLE -> SETUP -> ENABLE -> HOLD -> DONE)
//   cnt_width : width of the single phase down-counter, sized from the
//               longest of the three timed phases.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // The counter is loaded with (phase length - 1) and counts down to 0,
  // so it only has to represent values up to max-1.
  function automatic int cnt_width(input int setup_cyc, input int en_cyc, input int hold_cyc);
    int m;
    m = max3(setup_cyc, en_cyc, hold_cyc);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: returns the first set request bit
//   searching upward from the pointer, wrapping modulo NREQ.
//   Ports:
//     req    : request vector, one bit per requester
//     ptr    : highest-priority index for this search
//     winner : index of the selected requester (0 when none)
//     valid  : high when any request bit is set
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            valid
);

  // rot_idx[k] is the requester examined at search step k.
  logic [IDXW-1:0] rot_idx [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rot_idx[gi] = IDXW'((int'(ptr) + gi) % NREQ);
    end
  endgenerate

  // Scan from the farthest step back to step 0 so the closest set bit to
  // the pointer is the last one written and therefore wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[rot_idx[k]]) begin
        valid  = 1'b1;
        winner = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
//   Shares one D-latch word between NREQ requesters. Each write is sequenced
//   as setup -> enable -> hold so LD is stable around the whole LEN pulse,
//   then a one-cycle ACK is returned to the granted requester.
//   Ports:
//     CLK    : rising-edge clock
//     R      : asynchronous active-low reset
//     REQ    : per-requester write request (level, held until ACK)
//     WDATA  : packed write data, requester i in [i*WIDTH +: WIDTH]
//     ACK    : one-cycle completion pulse to the granted requester
//     GNT_ID : index of the current or last granted requester
//     BUSY   : high from grant until the cycle after ACK
//     LD     : registered data to latch D
//     LEN    : registered latch enable
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  localparam int IDXW     = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  R,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       ACK,
  output logic [IDXW-1:0]       GNT_ID,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      LD,
  output logic                  LEN
);

  localparam int CW = cnt_width(SETUP_CYC, EN_CYC, HOLD_CYC);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0]  ld_q, ld_d;
  logic              len_q, len_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;

  logic [IDXW-1:0]   arb_winner;
  logic              arb_valid;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req    (REQ),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    ld_d     = ld_q;
    len_d    = len_q;
    busy_d   = busy_q;
    ack_d    = '0;

    case (state_q)
      IDLE: begin
        // LD is captured only here, so D never moves during enable or hold.
        if (arb_valid) begin
          gnt_id_d = arb_winner;
          ld_d     = WDATA[arb_winner*WIDTH +: WIDTH];
          busy_d   = 1'b1;
          ptr_d    = (arb_winner == IDXW'(NREQ - 1)) ? '0 : arb_winner + 1'b1;
          cnt_d    = CW'(SETUP_CYC - 1);
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          len_d   = 1'b1;
          cnt_d   = CW'(EN_CYC - 1);
          state_d = ENABLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ENABLE: begin
        if (cnt_q == '0) begin
          len_d   = 1'b0;
          cnt_d   = CW'(HOLD_CYC - 1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          ack_d   = NREQ'(1) << gnt_id_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        len_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears LEN asynchronously so an interrupted write closes the latch
  // immediately; the transfer is abandoned without an ACK.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      ld_q     <= '0;
      len_q    <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      ld_q     <= ld_d;
      len_q    <= len_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign ACK    = ack_q;
  assign GNT_ID = gnt_id_q;
  assign BUSY   = busy_q;
  assign LD     = ld_q;
  assign LEN    = len_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter
//   Self-checking bench for latch_write_arbiter with default parameters.
//   Expected (requester, data) pairs are queued at grant time and popped when
//   the DUT pulses ACK; the sequencer timing is checked cycle by cycle.
module tb_latch_write_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  CLK = 1'b0;
  logic                  R   = 1'b0;
  logic [NREQ-1:0]       REQ = '0;
  logic [NREQ*WIDTH-1:0] WDATA = '0;
  logic [NREQ-1:0]       ACK;
  logic [1:0]            GNT_ID;
  logic                  BUSY;
  logic [WIDTH-1:0]      LD;
  logic                  LEN;

  latch_write_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1)
  ) dut (
    .CLK(CLK), .R(R), .REQ(REQ), .WDATA(WDATA),
    .ACK(ACK), .GNT_ID(GNT_ID), .BUSY(BUSY), .LD(LD), .LEN(LEN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ids[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard side: every ACK must match the oldest queued grant.
  always @(negedge CLK) begin
    if (R && ACK != '0) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(ACK), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_ack", 32'(ACK), 32'(4'b0001 << mon_e.id));
        check("sb_gnt", 32'(GNT_ID), 32'(mon_e.id));
        check("sb_ld", 32'(LD), 32'(mon_e.data));
        $display("ack: requester %0d data %02h", mon_e.id, LD);
      end
    end
  end

  // Drives REQ and follows n back-to-back transfers whose winners are in
  // exp_ids[0..n-1]. Called at a negedge with the DUT idle.
  task automatic run_grants(input logic [3:0] req, input int n);
    exp_t e;
    REQ = req;
    for (int k = 0; k < n; k++) begin
      e.id   = exp_ids[k];
      e.data = WDATA[exp_ids[k]*WIDTH +: WIDTH];
      sb.push_back(e);
      @(negedge CLK);
      $display("grant: req=%b expect id %0d data %02h, got id %0d data %02h",
               req, e.id, e.data, GNT_ID, LD);
      check("gnt_id", 32'(GNT_ID), 32'(e.id));
      check("ld_at_grant", 32'(LD), 32'(e.data));
      check("busy_grant", 32'(BUSY), 32'd1);
      check("len_setup", 32'(LEN), 32'd0);
      @(negedge CLK);
      check("len_e1", 32'(LEN), 32'd1);
      @(negedge CLK);
      check("len_e2", 32'(LEN), 32'd1);
      @(negedge CLK);
      check("len_e3", 32'(LEN), 32'd0);
      check("ld_hold", 32'(LD), 32'(e.data));
      @(negedge CLK);
      check("ack_pulse", 32'(ACK), 32'(4'b0001 << e.id));
      if (k == n - 1) REQ = '0;
      @(negedge CLK);
      check("busy_done", 32'(BUSY), 32'd0);
      check("ack_clear", 32'(ACK), 32'd0);
    end
  endtask

  initial begin
    // Reset held for two cycles, then ten idle cycles.
    repeat (2) begin
      @(negedge CLK);
      check("rst_outputs", {LEN, LD, ACK, BUSY, GNT_ID}, '0);
    end
    R = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      check("idle_outputs", {LEN, LD, ACK, BUSY, GNT_ID}, '0);
    end

    // Single write from requester 2.
    WDATA[2*WIDTH +: WIDTH] = 8'hA5;
    exp_ids[0] = 2;
    run_grants(4'b0100, 1);
    repeat (2) begin
      @(negedge CLK);
      check("ld_idle_hold", 32'(LD), 32'hA5);
    end

    // Reset pulse to bring the pointer back to 0.
    R = 1'b0;
    @(negedge CLK);
    R = 1'b1;

    // Full contention: grants rotate 0,1,2,3,0.
    WDATA = {8'h13, 8'h12, 8'h11, 8'h10};
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 2; exp_ids[3] = 3; exp_ids[4] = 0;
    run_grants(4'b1111, 5);

    // Pointer is 1: a lone request from 3, then 0 and 1 in order.
    exp_ids[0] = 3;
    run_grants(4'b1000, 1);
    exp_ids[0] = 0; exp_ids[1] = 1;
    run_grants(4'b0011, 2);

    // Pointer is 3 after granting 2: the search wraps to 0, then 1.
    exp_ids[0] = 2;
    run_grants(4'b0100, 1);
    exp_ids[0] = 0; exp_ids[1] = 1;
    run_grants(4'b0011, 2);

    // Stability: data and request of the granted requester change mid-write.
    WDATA[1*WIDTH +: WIDTH] = 8'h5A;
    REQ = 4'b0010;
    e_push(1, 8'h5A);
    @(negedge CLK);
    check("stab_gnt", 32'(GNT_ID), 32'd1);
    check("stab_ld_grant", 32'(LD), 32'h5A);
    @(negedge CLK);
    WDATA[1*WIDTH +: WIDTH] = 8'hFF;
    REQ = 4'b0000;
    check("stab_len_e1", 32'(LEN), 32'd1);
    check("stab_ld_e1", 32'(LD), 32'h5A);
    @(negedge CLK);
    check("stab_ld_e2", 32'(LD), 32'h5A);
    @(negedge CLK);
    check("stab_ld_hold", 32'(LD), 32'h5A);
    @(negedge CLK);
    check("stab_ack", 32'(ACK), 32'b0010);
    @(negedge CLK);
    check("stab_busy_done", 32'(BUSY), 32'd0);
    check("stab_ld_idle", 32'(LD), 32'h5A);

    // Reset while LEN is high: LEN must fall without a clock edge.
    WDATA = {8'h13, 8'h12, 8'h11, 8'h10};
    REQ = 4'b1111;
    @(negedge CLK);
    check("rmid_busy", 32'(BUSY), 32'd1);
    @(negedge CLK);
    check("rmid_len_before", 32'(LEN), 32'd1);
    #2 R = 1'b0;
    #1;
    $display("reset mid-write: LEN=%0b BUSY=%0b ACK=%b", LEN, BUSY, ACK);
    check("rmid_len_async", 32'(LEN), 32'd0);
    check("rmid_outputs", {LD, ACK, BUSY, GNT_ID}, '0);
    repeat (2) begin
      @(negedge CLK);
      check("rmid_no_ack", 32'(ACK), 32'd0);
    end
    R = 1'b1;
    exp_ids[0] = 0;
    run_grants(4'b1111, 1);

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic e_push(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

endmodule
